// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array controller:
// FSM state encoding and the clog2-derived width helpers.
package systolic_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int N_DEF    = 4;
   localparam int KMAX_DEF = 64;

   // k index width; never below one bit
   function automatic int addr_w(input int kmax);
      return (kmax > 1) ? $clog2(kmax) : 1;
   endfunction

   // feed counter width, covers 0..K+2N-3
   function automatic int cnt_w(input int kmax, input int n);
      return $clog2(kmax + 2 * n);
   endfunction

   localparam int AW_DEF = addr_w(KMAX_DEF);
   localparam int CW_DEF = cnt_w(KMAX_DEF, N_DEF);

endpackage

// File: rtl/systolic_ctrl_skew.sv
// One edge lane of the array feed: turns the shared feed count
// into a skewed, registered operand valid and k index.
module skew_lane
   import systolic_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CW-1:0] t,
   input  logic [CW-1:0] idx,
   input  logic [AW:0]   k,
   output logic          vld,
   output logic [AW-1:0] addr
);

   localparam int LW = (CW > AW + 1) ? CW : AW + 1;

   logic [CW-1:0] d;
   logic          hit;

   // lane i sees k index t-i while that index lies inside 0..K-1
   always_comb begin
      d   = t - idx;
      hit = en && (t >= idx) && (LW'(d) < LW'(k));
   end

   // register so the operand lines up with the cycle of t
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         addr <= '0;
      end else begin
         vld  <= hit;
         addr <= hit ? d[AW-1:0] : '0;
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array:
// clears the PEs, feeds skewed A rows / B columns, then signals done.
module systolic_ctrl
   import systolic_ctrl_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int FRAC_WIDTH = 8,
   parameter  int N          = N_DEF,
   parameter  int KMAX       = KMAX_DEF,
   localparam int AW         = addr_w(KMAX),
   localparam int CW         = cnt_w(KMAX, N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [AW:0]     k_len,
   output logic            busy,
   output logic            done,
   output logic            arr_rst_n,
   output logic [N-1:0]    a_vld,
   output logic [N*AW-1:0] a_addr,
   output logic [N-1:0]    b_vld,
   output logic [N*AW-1:0] b_addr
);

   localparam logic [AW:0]   K_MAX = (AW + 1)'(KMAX);
   localparam logic [CW-1:0] SKEW  = CW'(2 * N - 2);

   // the fixed-point format belongs to the PE array only
   if (FRAC_WIDTH >= WIDTH) begin : g_fmt_no_int_bits
   end

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] t;
   logic [CW-1:0] t_nxt;
   logic [CW-1:0] t_inc;
   logic [CW-1:0] span;
   logic [AW:0]   k;
   logic [AW:0]   k_nxt;
   logic [AW:0]   k_in;
   logic          feed_nxt;

   // clamped K, feed length K+2N-2 and the next count
   always_comb begin
      k_in     = (k_len > K_MAX) ? K_MAX : k_len;
      span     = CW'(k) + SKEW;
      t_inc    = t + CW'(1);
      feed_nxt = (state_nxt == S_FEED);
   end

   // next-state logic; the counter only runs in FEED
   always_comb begin
      state_nxt = state;
      t_nxt     = '0;
      k_nxt     = k;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_CLEAR;
               k_nxt     = k_in;
            end
         end
         S_CLEAR: begin
            state_nxt = (k == '0) ? S_DONE : S_FEED;
         end
         S_FEED: begin
            if (t_inc == span) begin
               state_nxt = S_DRAIN;
            end else begin
               t_nxt = t_inc;
            end
         end
         S_DRAIN: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state, count, latched K and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         t         <= '0;
         k         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         arr_rst_n <= 1'b0;
      end else begin
         state     <= state_nxt;
         t         <= t_nxt;
         k         <= k_nxt;
         busy      <= (state_nxt != S_IDLE);
         done      <= (state_nxt == S_DONE);
         arr_rst_n <= (state_nxt != S_CLEAR);
      end
   end

   // lanes register from next-cycle count so outputs match t
   for (genvar i = 0; i < N; i++) begin : g_row
      skew_lane #(
         .AW (AW),
         .CW (CW)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (feed_nxt),
         .t     (t_nxt),
         .idx   (CW'(i)),
         .k     (k),
         .vld   (a_vld[i]),
         .addr  (a_addr[i*AW +: AW])
      );
   end

   for (genvar j = 0; j < N; j++) begin : g_col
      skew_lane #(
         .AW (AW),
         .CW (CW)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (feed_nxt),
         .t     (t_nxt),
         .idx   (CW'(j)),
         .k     (k),
         .vld   (b_vld[j]),
         .addr  (b_addr[j*AW +: AW])
      );
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: schedule model, behavioural PE array,
// per-cycle output compare and directed scenario checks.
module tb_systolic_ctrl;

   localparam int N    = 4;
   localparam int KMAX = 64;
   localparam int AW   = 6;
   localparam int W    = 16;
   localparam int FRAC = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW:0]     k_len = '0;
   logic            busy;
   logic            done;
   logic            arr_rst_n;
   logic [N-1:0]    a_vld;
   logic [N*AW-1:0] a_addr;
   logic [N-1:0]    b_vld;
   logic [N*AW-1:0] b_addr;

   systolic_ctrl #(
      .WIDTH      (W),
      .FRAC_WIDTH (FRAC),
      .N          (N),
      .KMAX       (KMAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .arr_rst_n (arr_rst_n),
      .a_vld     (a_vld),
      .a_addr    (a_addr),
      .b_vld     (b_vld),
      .b_addr    (b_addr)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // ---------------- schedule model ----------------
   // m_p = position in the product (0 idle, 1 clear, ...)
   int m_p   = 0;
   int m_k   = 0;
   bit m_rst = 1'b1;

   function automatic int done_pos(input int kk);
      return (kk == 0) ? 2 : kk + 2 * N + 1;
   endfunction

   function automatic bit m_done();
      return !m_rst && m_p != 0 && m_p == done_pos(m_k);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_rst = 1'b1;
         m_p   = 0;
      end else begin
         m_rst = 1'b0;
         if (m_p == 0) begin
            if (start) begin
               m_p = 1;
               m_k = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
            end
         end else if (m_p == done_pos(m_k)) begin
            m_p = 0;
         end else begin
            m_p++;
         end
      end
   end

   // per-cycle compare of every output against the model
   always @(negedge clk) begin : cmp
      logic            eb;
      logic            ed;
      logic            ea;
      logic [N-1:0]    ev;
      logic [N*AW-1:0] ead;
      bit              feed;
      int              t;
      if (cyc > 0) begin
         eb   = !m_rst && m_p != 0;
         ed   = m_done();
         ea   = !m_rst && m_p != 1;
         feed = !m_rst && m_k > 0 && m_p >= 2 && m_p <= m_k + 2 * N - 1;
         t    = m_p - 2;
         ev   = '0;
         ead  = '0;
         for (int i = 0; i < N; i++) begin
            if (feed && t >= i && t - i < m_k) begin
               ev[i]           = 1'b1;
               ead[i*AW +: AW] = AW'(t - i);
            end
         end
         chk("busy", busy, eb);
         chk("done", done, ed);
         chk("arr_rst_n", arr_rst_n, ea);
         chk("a_vld", a_vld, ev);
         chk("b_vld", b_vld, ev);
         chk("a_addr", a_addr, ead);
         chk("b_addr", b_addr, ead);
      end
   end

   // ---------------- behavioural PE array ----------------
   int mat_a [N][KMAX];
   int mat_b [KMAX][N];
   int acc   [N][N];
   int ar    [N][N];
   int br    [N][N];

   always @(posedge clk) begin : pe
      int wa [N];
      int nb [N];
      int ain;
      int bin;
      for (int i = 0; i < N; i++)
         wa[i] = a_vld[i] ? mat_a[i][a_addr[i*AW +: AW]] : 0;
      for (int j = 0; j < N; j++)
         nb[j] = b_vld[j] ? mat_b[b_addr[j*AW +: AW]][j] : 0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            ain = (j == 0) ? wa[i] : ar[i][j-1];
            bin = (i == 0) ? nb[j] : br[i-1][j];
            if (!arr_rst_n) begin
               acc[i][j] <= 0;
               ar[i][j]  <= 0;
               br[i][j]  <= 0;
            end else begin
               acc[i][j] <= acc[i][j] + ((ain * bin) >>> FRAC);
               ar[i][j]  <= ain;
               br[i][j]  <= bin;
            end
         end
      end
   end

   function automatic int calc(input int i, input int j, input int kk);
      int s = 0;
      for (int x = 0; x < kk; x++)
         s += (mat_a[i][x] * mat_b[x][j]) >>> FRAC;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_pe(input string tag, input int kk);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("%s_pe%0d%0d", tag, i, j), acc[i][j], calc(i, j, kk));
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int a2f, a2l, a2fa, a2la, b3f, b3l, b3n;
      int dn, dc, dc2, mdc, idlec, arr0, arr0b, anyv;

      for (int i = 0; i < N; i++)
         for (int x = 0; x < KMAX; x++)
            mat_a[i][x] = (i == x) ? 256 : 0;
      for (int x = 0; x < KMAX; x++)
         for (int j = 0; j < N; j++)
            mat_b[x][j] = (((x * N + j) % 16) + 1) * 256;

      // reset state
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_arr", arr_rst_n, 0);
      chk("rst_avld", a_vld, 0);
      chk("rst_baddr", b_addr, 0);
      rst_n = 1'b1;
      step();
      chk("rel_arr", arr_rst_n, 1);
      chk("rel_busy", busy, 0);

      // K=4, A=I: timing pins and results
      a2f = -1; a2l = -1; a2fa = -1; a2la = -1;
      b3f = -1; b3l = -1; b3n = 0;
      dn = 0; dc = -1; mdc = -1; idlec = -1; arr0 = -1;
      k_len = 7'd4;
      start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         step();
         start = 1'b0;
         k_len = 7'd9;
         if (a_vld[2]) begin
            if (a2f < 0) begin
               a2f  = c;
               a2fa = int'(a_addr[2*AW +: AW]);
            end
            a2l  = c;
            a2la = int'(a_addr[2*AW +: AW]);
         end
         if (b_vld[3]) begin
            if (b3f < 0) b3f = c;
            b3l = c;
            b3n++;
         end
         if (done) begin
            dn++;
            dc = c;
         end
         if (m_done()) mdc = c;
         if (!busy && idlec < 0) idlec = c;
         if (!arr_rst_n && arr0 < 0) arr0 = c;
         if (c == 13 || c == 18)
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  chk($sformatf("k4_c%0d_pe%0d%0d", c, i, j),
                      acc[i][j], (i * N + j + 1) * 256);
      end
      chk("k4_arr0_cyc", arr0, 1);
      chk("k4_a2_first", a2f, 4);
      chk("k4_a2_first_addr", a2fa, 0);
      chk("k4_a2_last", a2l, 7);
      chk("k4_a2_last_addr", a2la, 3);
      chk("k4_b3_first", b3f, 5);
      chk("k4_b3_last", b3l, 8);
      chk("k4_b3_count", b3n, 4);
      chk("k4_done_cyc", dc, 13);
      chk("k4_done_count", dn, 1);
      chk("k4_model_done_cyc", mdc, 13);
      chk("k4_idle_cyc", idlec, 14);

      // K=0: clear then done, no operands
      dc = -1; arr0 = -1; anyv = 0;
      k_len = 7'd0;
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         start = 1'b0;
         if ((a_vld | b_vld) != 0) anyv = 1;
         if (!arr_rst_n && arr0 < 0) arr0 = c;
         if (done) begin
            dc = c;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  chk($sformatf("k0_pe%0d%0d", i, j), acc[i][j], 0);
         end
      end
      chk("k0_arr0_cyc", arr0, 1);
      chk("k0_done_cyc", dc, 2);
      chk("k0_any_vld", anyv, 0);

      // reset in FEED at t=5, then a fresh product
      k_len = 7'd4;
      start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step();
         start = 1'b0;
      end
      chk("mid_a_vld_t5", a_vld, 4'b1100);
      chk("mid_b_vld_t5", b_vld, 4'b1100);
      rst_n = 1'b0;
      step();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_arr", arr_rst_n, 0);
      chk("mid_rst_vld", {a_vld, b_vld}, 0);
      rst_n = 1'b1;
      step();
      chk("mid_rel_arr", arr_rst_n, 1);
      dn = 0; dc = -1;
      k_len = 7'd3;
      start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step();
         start = 1'b0;
         if (done) begin
            dn++;
            dc = c;
            chk_pe("k3", 3);
         end
      end
      chk("k3_done_cyc", dc, 12);
      chk("k3_done_count", dn, 1);

      // start held high with K=2: back-to-back products
      dn = 0; dc = -1; dc2 = -1; arr0 = -1; arr0b = -1;
      k_len = 7'd2;
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (c == 23) start = 1'b0;
         if (!arr_rst_n) begin
            if (arr0 < 0) arr0 = c;
            else arr0b = c;
         end
         if (done) begin
            dn++;
            if (dc < 0) dc = c;
            else dc2 = c;
            chk_pe($sformatf("b2b_c%0d", c), 2);
         end
      end
      chk("b2b_clear1", arr0, 1);
      chk("b2b_clear2", arr0b, 13);
      chk("b2b_done1", dc, 11);
      chk("b2b_done2", dc2, 23);
      chk("b2b_done_count", dn, 2);

      // k_len above KMAX clamps; start and k_len ignored while busy
      dn = 0; dc = -1;
      k_len = 7'd100;
      start = 1'b1;
      for (int c = 1; c <= 90; c++) begin
         step();
         start = 1'b0;
         k_len = 7'd5;
         if (c == 10) begin
            start = 1'b1;
            k_len = 7'd2;
         end
         if (done) begin
            dn++;
            dc = c;
            chk_pe("clamp", KMAX);
         end
      end
      chk("clamp_done_cyc", dc, 73);
      chk("clamp_done_count", dn, 1);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

endmodule
